// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter in front of a single SDRAM controller command port.
// VGA has fixed priority, ICACHE/DATA round-robin, and starved requesters are promoted above VGA.
module sdram_port_arbiter #(
  parameter int unsigned LINE_LEN     = 15,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 1023
) (
  input  logic         sdram_clk,
  input  logic         reset,
  input  logic         vga_req,
  input  logic [31:0]  vga_addr,
  output logic         vga_valid,
  output logic         vga_done,
  input  logic         ic_req,
  input  logic [31:0]  ic_addr,
  output logic         ic_valid,
  output logic         ic_done,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [31:0]  d_addr,
  input  logic [7:0]   d_len,
  input  logic [3:0]   d_mask,
  input  logic [511:0] d_wdata,
  output logic         d_valid,
  output logic         d_done,
  output logic [31:0]  rdata,
  output logic         mem_ren,
  output logic         mem_wen,
  output logic [31:0]  mem_addr,
  output logic [7:0]   mem_len,
  output logic [3:0]   mem_mask,
  output logic [511:0] mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_rvalid,
  input  logic         mem_done,
  output logic         timeout_err
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RELEASE} state_t;
  typedef enum logic [1:0] {G_NONE, G_VGA, G_IC, G_D} grant_t;

  state_t         r_state, w_state_next;
  grant_t         r_grant, w_win;
  logic           r_rr_d;
  logic [SW-1:0]  r_ic_cnt, r_d_cnt;
  logic [TW-1:0]  r_tmo;
  logic           r_we;
  logic           r_vga_valid, r_ic_valid, r_d_valid;
  logic           r_vga_done, r_ic_done, r_d_done;
  logic [31:0]    r_rdata;
  logic           r_mem_ren, r_mem_wen;
  logic [31:0]    r_mem_addr;
  logic [7:0]     r_mem_len;
  logic [3:0]     r_mem_mask;
  logic [511:0]   r_mem_wdata;
  logic           r_timeout_err;
  logic           w_ic_prom, w_d_prom, w_tmo_hit, w_busy_end;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] c);
    return (c >= SW'(STARVE_LIMIT)) ? c : c + SW'(1);
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_win        = G_NONE;
    w_state_next = r_state;
    w_ic_prom    = ic_req && (r_ic_cnt >= SW'(STARVE_LIMIT));
    w_d_prom     = d_req && (r_d_cnt >= SW'(STARVE_LIMIT));
    w_tmo_hit    = (r_tmo == TW'(TIMEOUT - 1)) && !mem_done;
    w_busy_end   = mem_done || w_tmo_hit;

    if (w_ic_prom && w_d_prom) w_win = r_rr_d ? G_D : G_IC;
    else if (w_ic_prom)        w_win = G_IC;
    else if (w_d_prom)         w_win = G_D;
    else if (vga_req)          w_win = G_VGA;
    else if (ic_req && d_req)  w_win = r_rr_d ? G_D : G_IC;
    else if (ic_req)           w_win = G_IC;
    else if (d_req)            w_win = G_D;

    unique case (r_state)
      S_IDLE:    if (w_win != G_NONE) w_state_next = S_ISSUE;
      S_ISSUE:   w_state_next = S_BUSY;
      S_BUSY:    if (w_busy_end) w_state_next = S_RELEASE;
      S_RELEASE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sdram_clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge sdram_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (reset) begin
      r_grant       <= G_NONE;
      r_rr_d        <= 1'b0;
      r_ic_cnt      <= '0;
      r_d_cnt       <= '0;
      r_tmo         <= '0;
      r_we          <= 1'b0;
      r_vga_valid   <= 1'b0;
      r_ic_valid    <= 1'b0;
      r_d_valid     <= 1'b0;
      r_vga_done    <= 1'b0;
      r_ic_done     <= 1'b0;
      r_d_done      <= 1'b0;
      r_rdata       <= '0;
      r_mem_ren     <= 1'b0;
      r_mem_wen     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_len     <= '0;
      r_mem_mask    <= '0;
      r_mem_wdata   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_vga_valid <= 1'b0;
      r_ic_valid  <= 1'b0;
      r_d_valid   <= 1'b0;
      r_vga_done  <= 1'b0;
      r_ic_done   <= 1'b0;
      r_d_done    <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_win != G_NONE) begin
            r_grant  <= w_win;
            r_ic_cnt <= (w_win == G_IC) ? '0 : (ic_req ? sat_inc(r_ic_cnt) : r_ic_cnt);
            r_d_cnt  <= (w_win == G_D)  ? '0 : (d_req  ? sat_inc(r_d_cnt)  : r_d_cnt);
            if (w_win == G_IC) r_rr_d <= 1'b1;
            if (w_win == G_D)  r_rr_d <= 1'b0;
            if (w_win == G_D) begin
              r_mem_addr  <= d_addr;
              r_mem_len   <= d_len;
              r_mem_mask  <= d_mask;
              r_mem_wdata <= d_wdata;
              r_we        <= d_we;
            end else begin
              r_mem_addr  <= (w_win == G_VGA) ? vga_addr : ic_addr;
              r_mem_len   <= 8'(LINE_LEN);
              r_mem_mask  <= '0;
              r_mem_wdata <= '0;
              r_we        <= 1'b0;
            end
          end
        end
        S_ISSUE: begin
          r_mem_ren <= !r_we;
          r_mem_wen <= r_we;
          r_tmo     <= '0;
        end
        S_BUSY: begin
          r_tmo <= r_tmo + TW'(1);
          if (mem_rvalid) begin
            r_rdata     <= mem_rdata;
            r_vga_valid <= (r_grant == G_VGA);
            r_ic_valid  <= (r_grant == G_IC);
            r_d_valid   <= (r_grant == G_D);
          end
          // A timeout completes the transaction exactly like mem_done, plus the sticky flag.
          if (w_busy_end) begin
            r_vga_done <= (r_grant == G_VGA);
            r_ic_done  <= (r_grant == G_IC);
            r_d_done   <= (r_grant == G_D);
          end
          if (w_tmo_hit) r_timeout_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign vga_valid   = r_vga_valid;
  assign vga_done    = r_vga_done;
  assign ic_valid    = r_ic_valid;
  assign ic_done     = r_ic_done;
  assign d_valid     = r_d_valid;
  assign d_done      = r_d_done;
  assign rdata       = r_rdata;
  assign mem_ren     = r_mem_ren;
  assign mem_wen     = r_mem_wen;
  assign mem_addr    = r_mem_addr;
  assign mem_len     = r_mem_len;
  assign mem_mask    = r_mem_mask;
  assign mem_wdata   = r_mem_wdata;
  assign timeout_err = r_timeout_err;

endmodule
